// File: rtl/ifetch_stage_if.sv
// Instruction-bus interface between the fetch stage and instruction memory.
//   req    : fetch request (master -> slave)
//   addr   : fetch address (master -> slave)
//   gnt    : request accepted this cycle (slave -> master)
//   rvalid : read data valid for the single outstanding request (slave -> master)
//   rdata  : instruction word (slave -> master)
`timescale 1ns/1ps
interface ifetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: issues one fetch per cycle from pc_i, tracks a
// single outstanding request, parks a response in a one-entry skid buffer
// while the pipeline is held, drops wrong-path responses after a jump and
// presents a registered IF/ID word to decode.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   jtag_rst_i      : debug reset, same effect as rst
//   pc_i            : current PC / fetch address
//   jump_en_i       : redirect this cycle
//   hold_en_i       : pipeline hold level, nonzero holds IF
//   ibus            : instruction bus (master side)
//   fetch_stall_o   : combinational, PC must not advance next edge
//   inst_o          : IF/ID instruction
//   inst_addr_o     : IF/ID instruction address
//   inst_valid_o    : IF/ID contents valid
`timescale 1ns/1ps
module ifetch_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jtag_rst_i,
  input  logic [31:0]         pc_i,
  input  logic                jump_en_i,
  input  logic [2:0]          hold_en_i,
  ifetch_stage_if.master      ibus,
  output logic                fetch_stall_o,
  output logic [31:0]         inst_o,
  output logic [31:0]         inst_addr_o,
  output logic                inst_valid_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic            reset;
  logic            hold;
  logic            can_issue;
  logic            accept;
  logic            resp_kept;

  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] skid_data;
  logic [XLEN-1:0] skid_addr;
  logic            skid_full;

  assign reset = rst | jtag_rst_i;
  assign hold  = (hold_en_i != 3'd0);

  // Outstanding-request FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Outstanding-request FSM: issue decision, next state and bus outputs
  always_comb begin
    state_nx      = state;
    can_issue     = 1'b0;
    accept        = 1'b0;
    resp_kept     = 1'b0;
    fetch_stall_o = 1'b0;

    // A new fetch may go out when the bus slot is free or frees this cycle
    can_issue = !reset && !jump_en_i && !hold && !skid_full &&
                ((state == ST_IDLE) || ibus.rvalid);
    accept    = can_issue && ibus.gnt;
    resp_kept = (state == ST_WAIT) && ibus.rvalid;

    fetch_stall_o = (can_issue && !ibus.gnt) ||
                    (!reset && !jump_en_i && !hold &&
                     (state != ST_IDLE) && !ibus.rvalid);

    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          if (accept) state_nx = ST_WAIT;
        end
        ST_WAIT: begin
          if (ibus.rvalid) begin
            state_nx = accept ? ST_WAIT : ST_IDLE;
          end else if (jump_en_i) begin
            // response still in flight belongs to the wrong path
            state_nx = ST_DROP;
          end
        end
        ST_DROP: begin
          if (ibus.rvalid) begin
            state_nx = accept ? ST_WAIT : ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign ibus.req  = can_issue;
  assign ibus.addr = pc_i;

  // Address of the request currently in flight
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= pc_i;
    end
  end

  // IF/ID register and skid buffer, in priority order
  always_ff @(posedge clk) begin
    if (reset || jump_en_i) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= RST_ADDR;
      inst_valid_o <= 1'b0;
      skid_full    <= 1'b0;
    end else if (hold) begin
      // decode is frozen; park a kept response until the hold lifts
      if (resp_kept) begin
        skid_data <= ibus.rdata;
        skid_addr <= req_addr;
        skid_full <= 1'b1;
      end
    end else if (skid_full) begin
      inst_o       <= skid_data;
      inst_addr_o  <= skid_addr;
      inst_valid_o <= 1'b1;
      skid_full    <= 1'b0;
    end else if (resp_kept) begin
      inst_o       <= ibus.rdata;
      inst_addr_o  <= req_addr;
      inst_valid_o <= 1'b1;
    end else begin
      // bubble keeps the last address for debug visibility
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ifetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RSTA = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        jtag_rst;
  logic [31:0] pc;
  logic        jump;
  logic [2:0]  hold_en;
  logic        fetch_stall;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;

  ifetch_stage_if bus ();

  ifetch_stage #(.NOP_INST(NOP), .RST_ADDR(RSTA)) dut (
    .clk           (clk),
    .rst           (rst),
    .jtag_rst_i    (jtag_rst),
    .pc_i          (pc),
    .jump_en_i     (jump),
    .hold_en_i     (hold_en),
    .ibus          (bus.master),
    .fetch_stall_o (fetch_stall),
    .inst_o        (inst),
    .inst_addr_o   (inst_addr),
    .inst_valid_o  (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one in-flight transaction with a keep/drop flag,
  // an optional parked response, and the expected IF/ID contents.
  logic        m_busy, m_keep;
  logic [31:0] m_addr;
  logic        m_skid_v;
  logic [31:0] m_skid_d, m_skid_a;
  logic [31:0] e_inst, e_addr;
  logic        e_valid;
  logic        last_accept;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // One clock cycle: drive inputs, check bus/stall, advance model, check IF/ID
  task automatic step(input logic r, input logic jt, input logic [31:0] p,
                      input logic j, input logic [2:0] h, input logic g,
                      input logic rv, input logic [31:0] rd);
    logic rs, hd, ex_req, ex_stall, kept;
    @(negedge clk);
    rst = r; jtag_rst = jt; pc = p; jump = j; hold_en = h;
    bus.gnt = g; bus.rvalid = rv; bus.rdata = rd;
    #1;
    rs = r | jt;
    hd = (h != 3'd0);
    ex_req   = !rs && !j && !hd && !m_skid_v && (!m_busy || rv);
    ex_stall = (ex_req && !g) || (!rs && !j && !hd && m_busy && !rv);
    check("ibus_req", 32'(bus.req), 32'(ex_req));
    check("fetch_stall", 32'(fetch_stall), 32'(ex_stall));
    check("ibus_addr", bus.addr, p);
    kept = m_busy && m_keep && rv;
    last_accept = ex_req && g;

    if (rs || j) begin
      e_inst = NOP; e_addr = RSTA; e_valid = 1'b0; m_skid_v = 1'b0;
    end else if (hd) begin
      if (kept) begin
        m_skid_v = 1'b1; m_skid_d = rd; m_skid_a = m_addr;
      end
    end else if (m_skid_v) begin
      e_inst = m_skid_d; e_addr = m_skid_a; e_valid = 1'b1; m_skid_v = 1'b0;
    end else if (kept) begin
      e_inst = rd; e_addr = m_addr; e_valid = 1'b1;
    end else begin
      e_inst = NOP; e_valid = 1'b0;
    end

    if (rs) begin
      m_busy = 1'b0;
    end else begin
      if (rv) m_busy = 1'b0;
      else if (j) m_keep = 1'b0;
      if (last_accept) begin
        m_busy = 1'b1; m_keep = 1'b1; m_addr = p;
      end
    end

    @(posedge clk);
    #1;
    check("inst", inst, e_inst);
    check("inst_addr", inst_addr, e_addr);
    check("inst_valid", 32'(inst_valid), 32'(e_valid));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] tb_pc;
  logic        bus_pending;
  int          bus_wait;
  logic [31:0] bus_addr;

  initial begin
    rst = 1'b1; jtag_rst = 1'b0; pc = '0; jump = 1'b0; hold_en = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    m_busy = 1'b0; m_keep = 1'b0; m_addr = '0;
    m_skid_v = 1'b0; m_skid_d = '0; m_skid_a = '0;
    e_inst = NOP; e_addr = RSTA; e_valid = 1'b0; last_accept = 1'b0;

    // Reset and zero-wait streaming
    do_reset();
    check("rst_inst", inst, NOP);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(bus.req), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h4, 1'b0, 3'd0, 1'b1, 1'b1, 32'h0050_0093);
    check("zw_inst0", inst, 32'h0050_0093);
    check("zw_addr0", inst_addr, 32'h0);
    step(1'b0, 1'b0, 32'h8, 1'b0, 3'd0, 1'b1, 1'b1, 32'h0010_0113);
    check("zw_inst1", inst, 32'h0010_0113);
    check("zw_addr1", inst_addr, 32'h4);
    step(1'b0, 1'b0, 32'hC, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0020_81B3);
    check("zw_inst2", inst, 32'h0020_81B3);
    check("zw_addr2", inst_addr, 32'h8);
    check("zw_valid2", 32'(inst_valid), 32'd1);

    // Grant withheld two cycles at 0x10
    do_reset();
    step(1'b0, 1'b0, 32'h10, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h10, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h10, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h14, 1'b0, 3'd0, 1'b0, 1'b1, 32'h1111_0010);
    check("gnt_inst", inst, 32'h1111_0010);
    check("gnt_addr", inst_addr, 32'h10);

    // Jump drops the outstanding 0x20 response; target 0x100 delivered
    do_reset();
    step(1'b0, 1'b0, 32'h20, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h24, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h100, 1'b0, 3'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("drop_valid", 32'(inst_valid), 32'd0);
    check("drop_inst", inst, NOP);
    step(1'b0, 1'b0, 32'h104, 1'b0, 3'd0, 1'b0, 1'b1, 32'h2222_0100);
    check("tgt_inst", inst, 32'h2222_0100);
    check("tgt_addr", inst_addr, 32'h100);

    // Hold for three cycles while 0x30 returns
    do_reset();
    step(1'b0, 1'b0, 32'h30, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h34, 1'b0, 3'd2, 1'b1, 1'b1, 32'h3333_0030);
    step(1'b0, 1'b0, 32'h34, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h34, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0);
    check("hold_valid", 32'(inst_valid), 32'd0);
    step(1'b0, 1'b0, 32'h34, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    check("skid_inst", inst, 32'h3333_0030);
    check("skid_addr", inst_addr, 32'h30);
    step(1'b0, 1'b0, 32'h34, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    check("next_fetch_accept", 32'(last_accept), 32'd1);

    // Jump together with hold while the skid is full
    do_reset();
    step(1'b0, 1'b0, 32'h30, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h34, 1'b0, 3'd1, 1'b1, 1'b1, 32'h4444_0030);
    step(1'b0, 1'b0, 32'h34, 1'b1, 3'd1, 1'b1, 1'b0, 32'h0);
    check("jh_inst", inst, NOP);
    check("jh_addr", inst_addr, RSTA);
    step(1'b0, 1'b0, 32'h200, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    check("jh_skid_cleared", 32'(inst_valid), 32'd0);

    // Debug reset while waiting; late response ignored
    do_reset();
    step(1'b0, 1'b0, 32'h40, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h44, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    check("jtag_inst", inst, NOP);
    step(1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 32'hBAD0_0040);
    check("late_valid", 32'(inst_valid), 32'd0);
    check("late_inst", inst, NOP);

    // Randomized traffic with a variable-latency memory
    do_reset();
    tb_pc = RSTA; bus_pending = 1'b0; bus_wait = 0; bus_addr = '0;
    for (int i = 0; i < 2000; i++) begin
      logic r, jt, j, g, rv;
      logic [2:0]  h;
      logic [31:0] rd, tgt;
      r   = ($urandom_range(0, 99) < 2);
      jt  = ($urandom_range(0, 199) < 1);
      j   = ($urandom_range(0, 99) < 8);
      h   = ($urandom_range(0, 99) < 20) ? 3'($urandom_range(1, 7)) : 3'd0;
      g   = ($urandom_range(0, 99) < 70);
      rv  = bus_pending && (bus_wait == 0);
      rd  = rv ? mem_data(bus_addr) : 32'($urandom);
      tgt = 32'($urandom_range(0, 1023)) << 2;
      step(r, jt, tb_pc, j, h, g, rv, rd);
      if (rv) bus_pending = 1'b0;
      else if (bus_pending) bus_wait--;
      if (r || jt) begin
        bus_pending = 1'b0;
        tb_pc = RSTA;
      end else begin
        if (last_accept) begin
          bus_pending = 1'b1;
          bus_addr    = tb_pc;
          bus_wait    = $urandom_range(0, 2);
        end
        if (j) tb_pc = tgt;
        else if (last_accept) tb_pc = tb_pc + 32'd4;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
